// File: rtl/mouse_pkg.sv
// Shared types and byte constants for the PS/2 mouse master sequencer.
// Waits become bounded when MOUSE_TIMEOUT_EN is defined.
package mouse_pkg;

  localparam int unsigned CNT_W = 24;

  typedef enum logic [3:0] {
    STARTUP,
    SEND_RST,
    WAIT_RST_SENT,
    WAIT_ACK1,
    WAIT_SELFTEST,
    WAIT_ID,
    SEND_EN,
    WAIT_EN_SENT,
    WAIT_ACK2,
    RX_STATUS,
    RX_DX,
    RX_DY,
    PUBLISH
  } state_e;

  localparam logic [7:0] CMD_RESET       = 8'hFF;
  localparam logic [7:0] CMD_ENABLE      = 8'hF4;
  localparam logic [7:0] RSP_ACK         = 8'hFA;
  localparam logic [7:0] RSP_SELFTEST_OK = 8'hAA;
  localparam logic [7:0] RSP_ID          = 8'h00;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_FRAME  = 2'b10;

  function automatic logic is_reading(input state_e s);
    case (s)
      WAIT_ACK1, WAIT_SELFTEST, WAIT_ID, WAIT_ACK2,
      RX_STATUS, RX_DX, RX_DY: is_reading = 1'b1;
      default:                 is_reading = 1'b0;
    endcase
  endfunction

  // States guarded by the response timeout; RX_STATUS is excluded on purpose.
  function automatic logic is_timed(input state_e s);
    case (s)
      WAIT_RST_SENT, WAIT_ACK1, WAIT_SELFTEST, WAIT_ID,
      WAIT_EN_SENT, WAIT_ACK2, RX_DX, RX_DY: is_timed = 1'b1;
      default:                               is_timed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mouse_wait_counter.sv
// Loadable 24-bit down-counter that sticks at zero; done_o flags the terminal count.
module mouse_wait_counter
  import mouse_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master: init dialogue (reset, self-test, enable) then 3-byte packet assembly.
// Define MOUSE_TIMEOUT_EN to bound every wait for a byte or BYTE_SENT.
module mouse_master_sm
  import mouse_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE_o,
  output logic [7:0] BYTE_TO_SEND_o,
  input  logic       BYTE_SENT_i,
  output logic       READ_ENABLE_o,
  input  logic [7:0] BYTE_READ_i,
  input  logic       BYTE_READY_i,
  input  logic [1:0] BYTE_ERROR_CODE_i,
  output logic [7:0] MOUSE_STATUS_o,
  output logic [7:0] MOUSE_DX_o,
  output logic [7:0] MOUSE_DY_o,
  output logic       SEND_INTERRUPT_o,
  output logic       INIT_DONE_o
);

  if (STARTUP_CYCLES >= (1 << CNT_W) || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_param_check
    $error("mouse_master_sm: cycle parameters must fit the 24-bit counter");
  end

  localparam logic [CNT_W-1:0] STARTUP_LOAD = CNT_W'(STARTUP_CYCLES);
`ifdef MOUSE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
`endif

  state_e           state_q, state_d;
  logic             armed_q, armed_d;
  logic             send_byte_q, send_byte_d;
  logic [7:0]       byte_to_send_q, byte_to_send_d;
  logic             read_enable_q, read_enable_d;
  logic [7:0]       cap_status_q, cap_status_d;
  logic [7:0]       cap_dx_q, cap_dx_d;
  logic [7:0]       cap_dy_q, cap_dy_d;
  logic [7:0]       status_q, status_d;
  logic [7:0]       dx_q, dx_d;
  logic [7:0]       dy_q, dy_d;
  logic             send_interrupt_q, send_interrupt_d;
  logic             init_done_q, init_done_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_done;
  logic             rx_ok, rx_bad;

  mouse_wait_counter u_wait_counter (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .done_o     (cnt_done)
  );

  assign rx_ok  = BYTE_READY_i && (BYTE_ERROR_CODE_i == ERR_OK);
  assign rx_bad = BYTE_READY_i && (BYTE_ERROR_CODE_i != ERR_OK);

  always_comb begin
    state_d          = state_q;
    armed_d          = armed_q;
    cnt_load         = 1'b0;
    cnt_load_val     = STARTUP_LOAD;
    send_byte_d      = 1'b0;
    byte_to_send_d   = byte_to_send_q;
    cap_status_d     = cap_status_q;
    cap_dx_d         = cap_dx_q;
    cap_dy_d         = cap_dy_q;
    status_d         = status_q;
    dx_d             = dx_q;
    dy_d             = dy_q;
    send_interrupt_d = 1'b0;
    init_done_d      = init_done_q;

    unique case (state_q)
      // The counter comes out of reset at zero, so STARTUP arms it before trusting done.
      STARTUP: begin
        if (!armed_q) begin
          cnt_load = 1'b1;
          armed_d  = 1'b1;
        end else if (cnt_done) begin
          armed_d = 1'b0;
          state_d = SEND_RST;
        end
      end
      SEND_RST: begin
        send_byte_d    = 1'b1;
        byte_to_send_d = CMD_RESET;
        state_d        = WAIT_RST_SENT;
      end
      WAIT_RST_SENT: if (BYTE_SENT_i) state_d = WAIT_ACK1;
      WAIT_ACK1: begin
        if (BYTE_READY_i) state_d = (rx_ok && BYTE_READ_i == RSP_ACK) ? WAIT_SELFTEST : STARTUP;
      end
      WAIT_SELFTEST: begin
        if (BYTE_READY_i) state_d = (rx_ok && BYTE_READ_i == RSP_SELFTEST_OK) ? WAIT_ID : STARTUP;
      end
      WAIT_ID: begin
        if (BYTE_READY_i) state_d = (rx_ok && BYTE_READ_i == RSP_ID) ? SEND_EN : STARTUP;
      end
      SEND_EN: begin
        send_byte_d    = 1'b1;
        byte_to_send_d = CMD_ENABLE;
        state_d        = WAIT_EN_SENT;
      end
      WAIT_EN_SENT: if (BYTE_SENT_i) state_d = WAIT_ACK2;
      WAIT_ACK2: begin
        if (rx_ok && BYTE_READ_i == RSP_ACK) begin
          init_done_d = 1'b1;
          state_d     = RX_STATUS;
        end else if (BYTE_READY_i) begin
          state_d = STARTUP;
        end
      end
      RX_STATUS: begin
        if (rx_ok && BYTE_READ_i[3]) begin
          cap_status_d = BYTE_READ_i;
          state_d      = RX_DX;
        end
      end
      RX_DX: begin
        if (rx_bad) begin
          state_d = RX_STATUS;
        end else if (rx_ok) begin
          cap_dx_d = BYTE_READ_i;
          state_d  = RX_DY;
        end
      end
      RX_DY: begin
        if (rx_bad) begin
          state_d = RX_STATUS;
        end else if (rx_ok) begin
          cap_dy_d = BYTE_READ_i;
          state_d  = PUBLISH;
        end
      end
      PUBLISH: begin
        status_d         = cap_status_q;
        dx_d             = cap_dx_q;
        dy_d             = cap_dy_q;
        send_interrupt_d = 1'b1;
        state_d          = RX_STATUS;
      end
      default: state_d = STARTUP;
    endcase

`ifdef MOUSE_TIMEOUT_EN
    // A byte arriving on the expiry cycle still wins over the timeout.
    if (is_timed(state_q) && cnt_done && state_d == state_q) begin
      state_d = STARTUP;
    end
    if (state_d != state_q && is_timed(state_d)) begin
      cnt_load     = 1'b1;
      cnt_load_val = TIMEOUT_LOAD;
    end
`endif

    if (state_d == STARTUP && state_q != STARTUP) begin
      init_done_d = 1'b0;
    end

    read_enable_d = is_reading(state_d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q          <= STARTUP;
      armed_q          <= 1'b0;
      send_byte_q      <= 1'b0;
      byte_to_send_q   <= 8'h00;
      read_enable_q    <= 1'b0;
      cap_status_q     <= 8'h00;
      cap_dx_q         <= 8'h00;
      cap_dy_q         <= 8'h00;
      status_q         <= 8'h00;
      dx_q             <= 8'h00;
      dy_q             <= 8'h00;
      send_interrupt_q <= 1'b0;
      init_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      armed_q          <= armed_d;
      send_byte_q      <= send_byte_d;
      byte_to_send_q   <= byte_to_send_d;
      read_enable_q    <= read_enable_d;
      cap_status_q     <= cap_status_d;
      cap_dx_q         <= cap_dx_d;
      cap_dy_q         <= cap_dy_d;
      status_q         <= status_d;
      dx_q             <= dx_d;
      dy_q             <= dy_d;
      send_interrupt_q <= send_interrupt_d;
      init_done_q      <= init_done_d;
    end
  end

  assign SEND_BYTE_o      = send_byte_q;
  assign BYTE_TO_SEND_o   = byte_to_send_q;
  assign READ_ENABLE_o    = read_enable_q;
  assign MOUSE_STATUS_o   = status_q;
  assign MOUSE_DX_o       = dx_q;
  assign MOUSE_DY_o       = dy_q;
  assign SEND_INTERRUPT_o = send_interrupt_q;
  assign INIT_DONE_o      = init_done_q;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Bench for mouse_master_sm: acts as the PS/2 device, checks init dialogue, packet vectors and a random stream.
// The timeout scenario is exercised only when MOUSE_TIMEOUT_EN is defined.
module tb_mouse_master_sm;

  localparam int unsigned N = 50;
  localparam int unsigned T = 200;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE_o;
  logic [7:0] BYTE_TO_SEND_o;
  logic       BYTE_SENT_i = 1'b0;
  logic       READ_ENABLE_o;
  logic [7:0] BYTE_READ_i = 8'h00;
  logic       BYTE_READY_i = 1'b0;
  logic [1:0] BYTE_ERROR_CODE_i = 2'b00;
  logic [7:0] MOUSE_STATUS_o, MOUSE_DX_o, MOUSE_DY_o;
  logic       SEND_INTERRUPT_o;
  logic       INIT_DONE_o;

  mouse_master_sm #(.STARTUP_CYCLES(N), .TIMEOUT_CYCLES(T)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .SEND_BYTE_o       (SEND_BYTE_o),
    .BYTE_TO_SEND_o    (BYTE_TO_SEND_o),
    .BYTE_SENT_i       (BYTE_SENT_i),
    .READ_ENABLE_o     (READ_ENABLE_o),
    .BYTE_READ_i       (BYTE_READ_i),
    .BYTE_READY_i      (BYTE_READY_i),
    .BYTE_ERROR_CODE_i (BYTE_ERROR_CODE_i),
    .MOUSE_STATUS_o    (MOUSE_STATUS_o),
    .MOUSE_DX_o        (MOUSE_DX_o),
    .MOUSE_DY_o        (MOUSE_DY_o),
    .SEND_INTERRUPT_o  (SEND_INTERRUPT_o),
    .INIT_DONE_o       (INIT_DONE_o)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  logic rnd_mode = 1'b0;

  typedef struct {
    logic [7:0] s, x, y;
    int         cyc;
  } pkt_t;
  pkt_t exp_q[$];

  typedef struct {
    int              n;
    logic [4:0][7:0] b;
    logic [4:0][1:0] e;
    int              pulses;
    logic [7:0]      st, dx, dy;
  } vec_t;
  vec_t vecs[5];

  int         idx;
  logic [7:0] pk[3];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (SEND_INTERRUPT_o === 1'b1) begin
      pulse_cnt++;
      if (rnd_mode) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_unexpected_publish: got %02h/%02h/%02h expected none",
                   MOUSE_STATUS_o, MOUSE_DX_o, MOUSE_DY_o);
        end else begin
          pkt_t p;
          p = exp_q.pop_front();
          check8("rnd_status", MOUSE_STATUS_o, p.s);
          check8("rnd_dx", MOUSE_DX_o, p.x);
          check8("rnd_dy", MOUSE_DY_o, p.y);
          checkn("rnd_latency", cyc, p.cyc + 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_send(output logic [7:0] b, output int waited, input int limit);
    waited = 0;
    while (SEND_BYTE_o !== 1'b1 && waited < limit) begin
      tick();
      waited++;
    end
    b = BYTE_TO_SEND_o;
    if (SEND_BYTE_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no SEND_BYTE expected one within %0d cycles", limit);
    end
  endtask

  task automatic send_ready(input logic [7:0] b, input logic [1:0] e);
    BYTE_READ_i       = b;
    BYTE_ERROR_CODE_i = e;
    BYTE_READY_i      = 1'b1;
    tick();
    BYTE_READY_i      = 1'b0;
    BYTE_ERROR_CODE_i = 2'b00;
  endtask

  task automatic pulse_sent();
    BYTE_SENT_i = 1'b1;
    tick();
    BYTE_SENT_i = 1'b0;
  endtask

  task automatic run_init(input logic [7:0] st_rsp);
    logic [7:0] b;
    int w;
    wait_send(b, w, N + 40);
    check8("rst_cmd", b, 8'hFF);
    check1("startup_delay_window", (w >= N && w <= N + 5), 1'b1);
    tick();
    check1("send_one_cycle", SEND_BYTE_o, 1'b0);
    check1("ren_low_tx", READ_ENABLE_o, 1'b0);
    tick();
    pulse_sent();
    check1("ren_ack1", READ_ENABLE_o, 1'b1);
    send_ready(8'hFA, 2'b00);
    tick();
    send_ready(st_rsp, 2'b00);
    if (st_rsp != 8'hAA) begin
      check1("ren_after_bad_selftest", READ_ENABLE_o, 1'b0);
      check1("init_done_bad_selftest", INIT_DONE_o, 1'b0);
      return;
    end
    tick();
    send_ready(8'h00, 2'b00);
    wait_send(b, w, 10);
    check8("en_cmd", b, 8'hF4);
    check1("ren_low_en", READ_ENABLE_o, 1'b0);
    tick();
    tick();
    pulse_sent();
    check1("init_done_before_ack", INIT_DONE_o, 1'b0);
    send_ready(8'hFA, 2'b00);
    check1("init_done", INIT_DONE_o, 1'b1);
    check1("ren_stream", READ_ENABLE_o, 1'b1);
  endtask

  task automatic rnd_byte(input logic [7:0] b, input logic [1:0] e);
    send_ready(b, e);
    if (idx == 0) begin
      if (b[3] && e == 2'b00) begin
        pk[0] = b;
        idx   = 1;
      end
    end else if (e != 2'b00) begin
      idx = 0;
    end else begin
      pk[idx] = b;
      idx++;
      if (idx == 3) begin
        exp_q.push_back('{pk[0], pk[1], pk[2], cyc});
        idx = 0;
      end
    end
    repeat ($urandom_range(1, 3)) tick();
  endtask

  initial begin
    logic [7:0] rb;
    logic [1:0] re;
    int p0;
    logic [7:0] b;
    int w;

    vecs[0] = '{3, 40'h00_00_F0_05_28, 10'b00_00_00_00_00, 1, 8'h28, 8'h05, 8'hF0};
    vecs[1] = '{4, 40'h00_02_01_08_05, 10'b00_00_00_00_00, 1, 8'h08, 8'h01, 8'h02};
    vecs[2] = '{5, 40'h04_03_09_11_08, 10'b00_00_00_01_00, 1, 8'h09, 8'h03, 8'h04};
    vecs[3] = '{4, 40'h00_06_07_18_08, 10'b00_00_00_00_10, 1, 8'h18, 8'h07, 8'h06};
    vecs[4] = '{3, 40'h00_00_55_7F_0C, 10'b00_00_10_00_00, 0, 8'h18, 8'h07, 8'h06};

    RESET = 1'b1;
    tick();
    tick();
    check1("rst_send_byte", SEND_BYTE_o, 1'b0);
    check8("rst_byte_to_send", BYTE_TO_SEND_o, 8'h00);
    check1("rst_read_enable", READ_ENABLE_o, 1'b0);
    check8("rst_status", MOUSE_STATUS_o, 8'h00);
    check8("rst_dx", MOUSE_DX_o, 8'h00);
    check8("rst_dy", MOUSE_DY_o, 8'h00);
    check1("rst_interrupt", SEND_INTERRUPT_o, 1'b0);
    check1("rst_init_done", INIT_DONE_o, 1'b0);
    RESET = 1'b0;

    run_init(8'hFC);
    run_init(8'hAA);

    for (int v = 0; v < 5; v++) begin
      p0 = pulse_cnt;
      for (int k = 0; k < vecs[v].n; k++) begin
        send_ready(vecs[v].b[k], vecs[v].e[k]);
        tick();
      end
      repeat (4) tick();
      checkn($sformatf("vec%0d_pulses", v), pulse_cnt - p0, vecs[v].pulses);
      check8($sformatf("vec%0d_status", v), MOUSE_STATUS_o, vecs[v].st);
      check8($sformatf("vec%0d_dx", v), MOUSE_DX_o, vecs[v].dx);
      check8($sformatf("vec%0d_dy", v), MOUSE_DY_o, vecs[v].dy);
      check1($sformatf("vec%0d_init_done", v), INIT_DONE_o, 1'b1);
    end

    rnd_mode = 1'b1;
    idx = 0;
    for (int i = 0; i < 200; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 9) < 6) rb[3] = 1'b1;
      re = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rnd_byte(rb, re);
    end
    while (idx != 0) rnd_byte(8'h10, 2'b00);
    repeat (6) tick();
    check1("rnd_all_published", (exp_q.size() == 0), 1'b1);
    check1("init_done_kept", INIT_DONE_o, 1'b1);
    rnd_mode = 1'b0;

`ifdef MOUSE_TIMEOUT_EN
    send_ready(8'h08, 2'b00);
    repeat (T - 3) tick();
    check1("init_done_before_timeout", INIT_DONE_o, 1'b1);
    repeat (8) tick();
    check1("init_done_cleared_timeout", INIT_DONE_o, 1'b0);
    check1("ren_low_timeout", READ_ENABLE_o, 1'b0);
    wait_send(b, w, N + 20);
    check8("timeout_rst_cmd", b, 8'hFF);
    tick();
    wait_send(b, w, T + N + 30);
    check8("retry_rst_cmd", b, 8'hFF);
    check1("retry_window", (w >= T + N && w <= T + N + 8), 1'b1);
    check1("init_done_noresp", INIT_DONE_o, 1'b0);
`endif

    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check1("reset_clears_init_done", INIT_DONE_o, 1'b0);
    wait_send(b, w, N + 20);
    RESET = 1'b1;
    tick();
    check1("abort_send_byte", SEND_BYTE_o, 1'b0);
    check8("abort_byte_to_send", BYTE_TO_SEND_o, 8'h00);
    check1("abort_read_enable", READ_ENABLE_o, 1'b0);
    RESET = 1'b0;
    tick();
    tick();
    check1("no_send_after_abort", SEND_BYTE_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected end within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mouse_master_sm.md
# mouse_master_sm

Top-level sequencer for the PS/2 mouse interface. It owns the byte-level transmitter and receiver. It runs the power-up initialisation dialogue (reset, self-test, enable streaming), then assembles 3-byte movement packets. It presents status, X and Y deltas to the rest of the design together with a one-cycle update strobe.

## Interface
- STARTUP_CYCLES, 1_000_000: idle cycles after reset before the first command (10 ms @ 100 MHz).
- TIMEOUT_CYCLES, 10_000_000: maximum wait for any expected byte or BYTE_SENT (100 ms); only used with MOUSE_TIMEOUT_EN.
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  synchronous, active-high.
- SEND_BYTE  out  1  one-cycle request to the transmitter.
- BYTE_TO_SEND  out  8  command byte; valid while SEND_BYTE is high.
- BYTE_SENT  in  1  one-cycle pulse from the transmitter when the device has acknowledged the frame.
- READ_ENABLE  out  1  receiver enable.
- BYTE_READ  in  8  received byte.
- BYTE_READY  in  1  one-cycle pulse; qualifies BYTE_READ and BYTE_ERROR_CODE.
- BYTE_ERROR_CODE  in  2  00 = ok, 01 = parity error, 10 = framing error.
- MOUSE_STATUS  out  8  last packet byte 0.
- MOUSE_DX  out  8  last packet byte 1.
- MOUSE_DY  out  8  last packet byte 2.
- SEND_INTERRUPT  out  1  one-cycle pulse when a new packet is published.
- INIT_DONE  out  1  high once streaming has been enabled.

## Operation
- States: STARTUP, SEND_RST, WAIT_RST_SENT, WAIT_ACK1, WAIT_SELFTEST, WAIT_ID, SEND_EN, WAIT_EN_SENT, WAIT_ACK2, RX_STATUS, RX_DX, RX_DY, PUBLISH.
- STARTUP: counts STARTUP_CYCLES, then goes to SEND_RST.
- SEND_RST: asserts SEND_BYTE with 0xFF for exactly one cycle, then goes to WAIT_RST_SENT. That state waits for BYTE_SENT.
- WAIT_ACK1 expects 0xFA. WAIT_SELFTEST expects 0xAA. WAIT_ID expects 0x00.
- SEND_EN sends 0xF4. WAIT_EN_SENT then waits for BYTE_SENT. WAIT_ACK2 expects 0xFA; on success INIT_DONE is set.
- In the expect-states, a BYTE_READY carrying a wrong value or a nonzero BYTE_ERROR_CODE goes to STARTUP. This retries the whole dialogue, with the counter reloaded.
- READ_ENABLE is high in every WAIT_ACK*, WAIT_SELFTEST, WAIT_ID and RX_* state. It is low in all others, including during transmission.
- RX_STATUS: accepts a byte only if bit 3 is 1 and the error code is 00; otherwise it discards the byte and stays (resync). Accepted bytes are captured into internal registers.
- RX_DX and RX_DY: a byte with a nonzero error code sends the FSM back to RX_STATUS and drops the partial packet. An ok byte is captured.
- PUBLISH (one cycle): copies the three captured bytes to MOUSE_STATUS/DX/DY, pulses SEND_INTERRUPT, and returns to RX_STATUS.
- Streaming errors never clear INIT_DONE. Only a re-init path (timeout or RESET) clears it.

## Timing
- Reset values: SEND_BYTE = 0, BYTE_TO_SEND = 0x00, READ_ENABLE = 0, MOUSE_STATUS/DX/DY = 0x00, SEND_INTERRUPT = 0, INIT_DONE = 0. The state is STARTUP with the counter cleared.
- All outputs are registered.
- SEND_BYTE rises in the cycle after entry to SEND_*.
- SEND_INTERRUPT and the new output values appear together, 2 cycles after the BYTE_READY that completed DY.
- BYTE_READY in the same cycle as a state change into a non-reading state is ignored.
- RESET mid-transfer aborts immediately. SEND_BYTE is never left high.
- The counter is 24 bits. It saturates at its terminal value and does not wrap.

## Configuration
- MOUSE_TIMEOUT_EN defined: the counter restarts on entry to every WAIT_* and RX_DX/RX_DY state.
  - Reaching TIMEOUT_CYCLES goes to STARTUP, clearing INIT_DONE.
  - RX_STATUS never times out, because an idle mouse is legal.
- MOUSE_TIMEOUT_EN undefined: waits are unbounded, and the counter is used only in STARTUP.

## Structure
- Shared package mouse_pkg:
  - state enum;
  - command and response constants CMD_RESET = 0xFF, CMD_ENABLE = 0xF4, RSP_ACK = 0xFA, RSP_SELFTEST_OK = 0xAA, RSP_ID = 0x00;
  - error-code constants.
- One sub-module, mouse_wait_counter: a loadable, saturating 24-bit down-counter with a done flag. It serves both the startup delay and the timeout.

## Test plan
- Clean init: after the startup delay, the bench model answers BYTE_SENT, 0xFA, 0xAA, 0x00, BYTE_SENT, 0xFA. Required: BYTE_TO_SEND sequence 0xFF then 0xF4, and INIT_DONE = 1 one cycle after the final 0xFA.
- Bad self-test: the bench returns 0xFC instead of 0xAA. Required: back to STARTUP, and after STARTUP_CYCLES a second 0xFF is sent.
- Packet: 0x28, 0x05, 0xF0. Required: STATUS = 0x28, DX = 0x05, DY = 0xF0, and exactly one SEND_INTERRUPT pulse.
- Resync: 0x05 (bit 3 clear), then 0x08, 0x01, 0x02. Required: the first byte is ignored, and the published packet is 0x08/0x01/0x02.
- Parity error on DX: 0x08, then 0x11 with error 01, then 0x09, 0x03, 0x04. Required: only packet 0x09/0x03/0x04 is published.
- With MOUSE_TIMEOUT_EN: no response after the 0xFF send. Required: STARTUP re-entered after TIMEOUT_CYCLES, and INIT_DONE stays 0.
